// File: rtl/bin2bcd_stream_if.sv
// Handshake bundle for bin2bcd_stream: binary operand stream in,
// packed BCD result stream out, plus the busy status flag.
interface bin2bcd_stream_if #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10
);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    logic [BIN_W-1:0]    bin_data;
    logic                bin_valid;
    logic                bin_ready;
    logic [4*DIGITS-1:0] bcd_data;
    logic [NDIG_W-1:0]   bcd_ndig;
    logic                bcd_neg;
    logic                bcd_valid;
    logic                bcd_ready;
    logic                busy;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output bin_data, bin_valid, bcd_ready,
        input  bin_ready, bcd_data, bcd_ndig, bcd_neg, bcd_valid, busy
    );

    // Converter side
    modport slave (
        input  bin_data, bin_valid, bcd_ready,
        output bin_ready, bcd_data, bcd_ndig, bcd_neg, bcd_valid, busy
    );
endinterface

// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter (iterative double dabble, one bit per
// cycle) with a one-entry input buffer so the next operand can wait while
// the current one converts. Reports the count of significant digits.
// Optional feature macro: BCD_SIGN_EN -- two's complement input; the
// magnitude is converted and the sign is reported on bcd_neg.
module bin2bcd_stream #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10
) (
    input logic              clk,
    input logic              rst,
    bin2bcd_stream_if.slave  io
);
    localparam int unsigned NDIG_W     = $clog2(DIGITS + 1);
    localparam int unsigned CNT_W      = $clog2(BIN_W);
    localparam int unsigned MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

    generate
        if (BIN_W < 2 || BIN_W > 64) begin : g_bad_width
            $error("bin2bcd_stream: BIN_W must be in 2..64");
        end
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("bin2bcd_stream: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   buf_full;
    logic [BIN_W-1:0]       buf_data;
    logic [BIN_W-1:0]       shreg;
    logic [4*DIGITS-1:0]    acc;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;
    logic                   load;
    logic                   step;
    logic                   last_step;
    logic [BIN_W-1:0]       load_value;
    logic [4*DIGITS+BIN_W-1:0] stepped;
    logic [NDIG_W-1:0]      ndig;

    // One double-dabble step: +3 on every digit >= 5, then shift {bcd, bin} left
    function automatic logic [4*DIGITS+BIN_W-1:0] dabble(
        input logic [4*DIGITS-1:0] a,
        input logic [BIN_W-1:0]    b
    );
        logic [4*DIGITS-1:0] adj;
        adj = a;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        return {adj[4*DIGITS-2:0], b, 1'b0};
    endfunction

    assign io.bin_ready = !buf_full && !rst;
    assign accept       = io.bin_valid && io.bin_ready;
    assign last_step    = (cnt == CNT_W'(BIN_W - 1));
    assign stepped      = dabble(acc, shreg);

    assign io.bcd_valid = (state == DONE);
    assign io.bcd_data  = acc;
    assign io.bcd_ndig  = ndig;
    assign io.busy      = buf_full || (state != IDLE);

`ifdef BCD_SIGN_EN
    logic sign;
    logic neg_q;

    assign sign       = buf_data[BIN_W-1];
    // Negating the most negative value yields 2^(BIN_W-1) as unsigned, as wanted
    assign load_value = sign ? (~buf_data + BIN_W'(1)) : buf_data;
    assign io.bcd_neg = neg_q;

    // Sign register, captured with the operand it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= sign;
        end
    end
`else
    assign load_value = buf_data;
    assign io.bcd_neg = 1'b0;
`endif

    // Input buffer: filled on accept, emptied when the core loads it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= io.bin_data;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    // Core state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Core next-state and load/step control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    load       = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (io.bcd_ready) begin
                    if (buf_full) begin
                        load       = 1'b1;
                        state_next = CONVERT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, BCD accumulator and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_value;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            {acc, shreg} <= stepped;
            cnt          <= cnt + CNT_W'(1);
        end
    end

    // Significant digits: position of the highest nonzero digit, minimum 1
    always_comb begin
        ndig = NDIG_W'(1);
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] != 4'd0) begin
                ndig = NDIG_W'(k + 1);
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_stream.sv
// Self-checking bench for bin2bcd_stream: table of directed vectors plus
// back-to-back, backpressure and mid-conversion reset sequences.
// Builds for BIN_W=32/DIGITS=10 by default, BIN_W=8/DIGITS=3 with BCD_SIGN_EN.
module tb_bin2bcd_stream;
`ifdef BCD_SIGN_EN
    localparam int unsigned BW = 8;
    localparam int unsigned DG = 3;
`else
    localparam int unsigned BW = 32;
    localparam int unsigned DG = 10;
`endif
    localparam int unsigned NV  = 8;
    localparam int          LIM = 4 * BW + 40;

    typedef struct {
        logic [BW-1:0]   bin;
        logic [4*DG-1:0] bcd;
        int unsigned     ndig;
        logic            neg;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    vec_t vecs[NV];
    vec_t b2b[3];
    vec_t rst_vec;

    bin2bcd_stream_if #(.BIN_W(BW), .DIGITS(DG)) io ();

    bin2bcd_stream #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [BW-1:0] v, input string name);
        int n;
        n = 0;
        io.bin_data  = v;
        io.bin_valid = 1'b1;
        while (!io.bin_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (!io.bin_ready) begin
            chk({name, "_accept_timeout"}, 64'(io.bin_ready), 64'd1);
            io.bin_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            io.bin_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!io.bcd_valid && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        if (!io.bcd_valid) chk({name, "_valid_timeout"}, 64'(io.bcd_valid), 64'd1);
    endtask

    task automatic consume();
        io.bcd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.bcd_ready = 1'b0;
    endtask

    task automatic chk_result(input string name, input vec_t v);
        chk({name, "_data"}, 64'(io.bcd_data), 64'(v.bcd));
        chk({name, "_ndig"}, 64'(io.bcd_ndig), 64'(v.ndig));
        chk({name, "_neg"},  64'(io.bcd_neg),  64'(v.neg));
    endtask

    initial begin : main
        int lat;
        int bad;
        int t1, t2, t3;
        int r[3];
        logic [4*DG-1:0] snap_data;
        logic [63:0]     snap_ndig;

`ifdef BCD_SIGN_EN
        vecs[0] = '{8'h80, 12'h128, 3, 1'b1};
        vecs[1] = '{8'hFF, 12'h001, 1, 1'b1};
        vecs[2] = '{8'h7F, 12'h127, 3, 1'b0};
        vecs[3] = '{8'h00, 12'h000, 1, 1'b0};
        vecs[4] = '{8'h01, 12'h001, 1, 1'b0};
        vecs[5] = '{8'h9C, 12'h100, 3, 1'b1};
        vecs[6] = '{8'hF6, 12'h010, 2, 1'b1};
        vecs[7] = '{8'h63, 12'h099, 2, 1'b0};
        b2b[0]  = '{8'h80, 12'h128, 3, 1'b1};
        b2b[1]  = '{8'h7F, 12'h127, 3, 1'b0};
        b2b[2]  = '{8'hF6, 12'h010, 2, 1'b1};
        rst_vec = '{8'h63, 12'h099, 2, 1'b0};
`else
        vecs[0] = '{32'hFFFF_FFFF,    40'h42_9496_7295, 10, 1'b0};
        vecs[1] = '{32'd0,            40'h0,             1, 1'b0};
        vecs[2] = '{32'd1000,         40'h1000,          4, 1'b0};
        vecs[3] = '{32'd99,           40'h99,            2, 1'b0};
        vecs[4] = '{32'd9,            40'h9,             1, 1'b0};
        vecs[5] = '{32'd10,           40'h10,            2, 1'b0};
        vecs[6] = '{32'd12345,        40'h12345,         5, 1'b0};
        vecs[7] = '{32'd4000000000,   40'h40_0000_0000, 10, 1'b0};
        b2b[0]  = '{32'd12345,        40'h12345,         5, 1'b0};
        b2b[1]  = '{32'd67890,        40'h67890,         5, 1'b0};
        b2b[2]  = '{32'd99,           40'h99,            2, 1'b0};
        rst_vec = '{32'd99,           40'h99,            2, 1'b0};
`endif

        io.bin_data  = '0;
        io.bin_valid = 1'b0;
        io.bcd_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_bin_ready", 64'(io.bin_ready), 64'd0);
        chk("rst_valid",     64'(io.bcd_valid), 64'd0);
        chk("rst_data",      64'(io.bcd_data),  64'd0);
        chk("rst_ndig",      64'(io.bcd_ndig),  64'd1);
        chk("rst_neg",       64'(io.bcd_neg),   64'd0);
        chk("rst_busy",      64'(io.busy),      64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_bin_ready", 64'(io.bin_ready), 64'd1);

        // Table-driven single conversions
        for (int i = 0; i < int'(NV); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send(vecs[i].bin, nm);
            chk({nm, "_busy"}, 64'(io.busy), 64'd1);
            wait_valid(nm, lat);
            chk({nm, "_latency"}, 64'(lat), 64'(BW + 1));
            chk_result(nm, vecs[i]);
            consume();
            chk({nm, "_idle_busy"},  64'(io.busy),      64'd0);
            chk({nm, "_idle_valid"}, 64'(io.bcd_valid), 64'd0);
        end

        // Back-to-back with consumer always ready
        io.bcd_ready = 1'b1;
        fork
            begin
                send(b2b[0].bin, "b2b0");
                t1 = cyc;
                send(b2b[1].bin, "b2b1");
                t2 = cyc;
                send(b2b[2].bin, "b2b2");
                t3 = cyc;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_valid($sformatf("b2b_res%0d", i), lat);
                    r[i] = cyc;
                    chk_result($sformatf("b2b_res%0d", i), b2b[i]);
                    @(negedge clk);
                end
            end
        join
        io.bcd_ready = 1'b0;
        chk("b2b_latency",        64'(r[0] - t1), 64'(BW + 1));
        chk("b2b_second_accept",  64'(t2 - t1),   64'd2);
        chk("b2b_accept_in_conv", 64'(t2 < r[0]), 64'd1);
        chk("b2b_spacing01",      64'(r[1] - r[0]), 64'(BW + 1));
        chk("b2b_spacing12",      64'(r[2] - r[1]), 64'(BW + 1));
        chk("b2b_third_stall",    64'(t3 - r[0]), 64'd2);
        @(negedge clk);
        chk("b2b_end_busy", 64'(io.busy), 64'd0);

        // Backpressure in DONE with an operand waiting in the buffer
        send(vecs[2].bin, "bp0");
        wait_valid("bp0", lat);
        send(vecs[3].bin, "bp1");
        snap_data = io.bcd_data;
        snap_ndig = 64'(io.bcd_ndig);
        chk_result("bp_hold", vecs[2]);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (io.bcd_valid !== 1'b1 || io.bcd_data !== snap_data ||
                64'(io.bcd_ndig) !== snap_ndig || io.bin_ready !== 1'b0 ||
                io.busy !== 1'b1)
                bad++;
        end
        chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
        consume();
        wait_valid("bp1", lat);
        chk("bp1_latency", 64'(lat), 64'(BW));
        chk_result("bp1", vecs[3]);
        consume();

        // Reset in the middle of a conversion with a second operand buffered
        send(vecs[0].bin, "mr0");
        send(vecs[2].bin, "mr1");
        repeat ((BW > 12) ? 8 : 2) @(negedge clk);
        chk("mr_pre_valid", 64'(io.bcd_valid), 64'd0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (io.bcd_valid !== 1'b0 || io.bin_ready !== 1'b0 || io.busy !== 1'b0)
                bad++;
        end
        chk("mr_during_rst_bad", 64'(bad), 64'd0);
        rst = 1'b0;
        io.bcd_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < int'(BW) + 6; i++) begin
            @(negedge clk);
            if (io.bcd_valid !== 1'b0 || io.busy !== 1'b0) bad++;
        end
        io.bcd_ready = 1'b0;
        chk("mr_no_stale_result", 64'(bad), 64'd0);
        send(rst_vec.bin, "mr_after");
        wait_valid("mr_after", lat);
        chk("mr_after_latency", 64'(lat), 64'(BW + 1));
        chk_result("mr_after", rst_vec);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
